// File: rtl/dmem_mmio_pkg.sv
// Shared constants and the address-decode helper for the data-memory / MMIO stage.
package dmem_mmio_pkg;

    localparam logic [31:0] ADDR_LED  = 32'hFFFF_FF00;
    localparam logic [31:0] ADDR_SW   = 32'hFFFF_FF04;
    localparam logic [31:0] ADDR_CNT  = 32'hFFFF_FF08;
    localparam logic [31:0] ADDR_CMP  = 32'hFFFF_FF0C;
    localparam logic [31:0] ADDR_STAT = 32'hFFFF_FF10;

    localparam logic [31:0] CMP_RESET      = 32'hFFFF_FFFF;
    localparam int          STAT_MATCH_BIT = 0;

    // Which target an access hits
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_CNT,
        SEL_CMP,
        SEL_STAT
    } sel_e;

    // Peripheral decode on the word address (byte offset bits already dropped)
    function automatic sel_e periph_sel(input logic [29:0] word);
        sel_e s;
        s = SEL_NONE;
        if (word == ADDR_LED[31:2])  s = SEL_LED;
        if (word == ADDR_SW[31:2])   s = SEL_SW;
        if (word == ADDR_CNT[31:2])  s = SEL_CNT;
        if (word == ADDR_CMP[31:2])  s = SEL_CMP;
        if (word == ADDR_STAT[31:2]) s = SEL_STAT;
        return s;
    endfunction

endpackage

// File: rtl/dmem_mmio_timer.sv
// Cycle counter, compare register and sticky match flag with their write priorities.
module mmio_timer
    import dmem_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cnt_we,
    input  logic        cmp_we,
    input  logic        stat_we,
    input  logic [31:0] wdata,
    input  sel_e        rd_sel,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cmp_q, cmp_d;
    logic        flag_q, flag_d;

    // Next state: a load beats the increment; a match beats a clear
    always_comb begin
        cnt_d  = cnt_we ? wdata : cnt_q + 32'd1;
        cmp_d  = cmp_we ? wdata : cmp_q;
        flag_d = flag_q;
        if (stat_we && wdata[STAT_MATCH_BIT]) flag_d = 1'b0;
        if (cnt_q == cmp_q)                   flag_d = 1'b1;
    end

    // Timer state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= 32'd0;
            cmp_q  <= CMP_RESET;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cmp_q  <= cmp_d;
            flag_q <= flag_d;
        end
    end

    // Read mux for the three timer registers
    always_comb begin
        rdata = '0;
        case (rd_sel)
            SEL_CNT:  rdata = cnt_q;
            SEL_CMP:  rdata = cmp_q;
            SEL_STAT: rdata[STAT_MATCH_BIT] = flag_q;
            default:  rdata = '0;
        endcase
    end

    assign irq = flag_q;

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory stage: word RAM plus LED, switch, and timer registers in a small MMIO window.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int SW_WIDTH    = 8,
    parameter int LED_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemWriteM,
    input  logic [31:0]          ALUOutM,
    input  logic [31:0]          WriteDataM,
    output logic [31:0]          ReadDataM,
    input  logic [SW_WIDTH-1:0]  sw_in,
    output logic [LED_WIDTH-1:0] led_out,
    output logic                 timer_irq
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]          ram [DEPTH_WORDS];
    logic [AW-1:0]        ram_idx;
    sel_e                 sel;
    logic                 we;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [SW_WIDTH-1:0]  sw_s1_q, sw_s1_d;
    logic [SW_WIDTH-1:0]  sw_s2_q, sw_s2_d;
    logic [31:0]          timer_rdata;

    // Byte offset is irrelevant for word-only accesses
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^ALUOutM[1:0];

    // Address decode; stores are blocked during reset
    always_comb begin
        ram_idx = ALUOutM[AW+1:2];
        if (ALUOutM[31:AW+2] == '0) sel = SEL_RAM;
        else                        sel = periph_sel(ALUOutM[31:2]);
        we = MemWriteM && !reset;
    end

    // RAM write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (we && sel == SEL_RAM) ram[ram_idx] <= WriteDataM;
    end

    // LED and switch synchronizer next state
    always_comb begin
        led_d   = (we && sel == SEL_LED) ? WriteDataM[LED_WIDTH-1:0] : led_q;
        sw_s1_d = sw_in;
        sw_s2_d = sw_s1_q;
    end

    // LED and synchronizer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q   <= '0;
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            led_q   <= led_d;
            sw_s1_q <= sw_s1_d;
            sw_s2_q <= sw_s2_d;
        end
    end

    mmio_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .cnt_we  (we && sel == SEL_CNT),
        .cmp_we  (we && sel == SEL_CMP),
        .stat_we (we && sel == SEL_STAT),
        .wdata   (WriteDataM),
        .rd_sel  (sel),
        .rdata   (timer_rdata),
        .irq     (timer_irq)
    );

    // Combinational load mux; unmapped addresses read zero
    always_comb begin
        ReadDataM = '0;
        case (sel)
            SEL_RAM:                   ReadDataM = ram[ram_idx];
            SEL_LED:                   ReadDataM[LED_WIDTH-1:0] = led_q;
            SEL_SW:                    ReadDataM[SW_WIDTH-1:0]  = sw_s2_q;
            SEL_CNT, SEL_CMP, SEL_STAT: ReadDataM = timer_rdata;
            default:                   ReadDataM = '0;
        endcase
    end

    assign led_out = led_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio with a behavioural reference model checked every cycle.
module tb_dmem_mmio;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic [7:0]  sw_in;
    logic [7:0]  led_out;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    dmem_mmio #(.DEPTH_WORDS(DEPTH), .SW_WIDTH(8), .LED_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .sw_in      (sw_in),
        .led_out    (led_out),
        .timer_irq  (timer_irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_ram [int];
    logic [7:0]  m_led;
    logic [31:0] m_cnt, m_cmp;
    bit          m_flag;
    logic [7:0]  m_s1, m_s2;
    bit          m_valid = 0;

    always @(posedge clk) begin
        bit hit;
        if (reset) begin
            m_led = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_flag = 0;
            m_s1 = 0; m_s2 = 0; m_valid = 1;
        end else begin
            hit  = (m_cnt == m_cmp);
            m_s2 = m_s1;
            m_s1 = sw_in;
            m_cnt = m_cnt + 1;
            if (MemWriteM) begin
                if (ALUOutM < DEPTH*4) m_ram[int'(ALUOutM >> 2)] = WriteDataM;
                else case (ALUOutM & ~32'h3)
                    32'hFFFF_FF00: m_led = WriteDataM[7:0];
                    32'hFFFF_FF08: m_cnt = WriteDataM;
                    32'hFFFF_FF0C: m_cmp = WriteDataM;
                    32'hFFFF_FF10: if (WriteDataM[0]) m_flag = 0;
                    default: ;
                endcase
            end
            if (hit) m_flag = 1;
        end
    end

    function automatic bit model_rd(input logic [31:0] a, output logic [31:0] v);
        v = 0;
        if (a < DEPTH*4) begin
            if (!m_ram.exists(int'(a >> 2))) return 0;
            v = m_ram[int'(a >> 2)];
            return 1;
        end
        case (a & ~32'h3)
            32'hFFFF_FF00: v = {24'd0, m_led};
            32'hFFFF_FF04: v = {24'd0, m_s2};
            32'hFFFF_FF08: v = m_cnt;
            32'hFFFF_FF0C: v = m_cmp;
            32'hFFFF_FF10: v = {31'd0, m_flag};
            default:       v = 0;
        endcase
        return 1;
    endfunction

    // Compare process: outputs against the model, away from the active edge
    always @(negedge clk) begin
        logic [31:0] exp_rd;
        if (m_valid) begin
            checks++;
            if (led_out !== m_led) begin
                errors++;
                $display("FAIL model_led t=%0t got %h want %h", $time, led_out, m_led);
            end
            checks++;
            if (timer_irq !== m_flag) begin
                errors++;
                $display("FAIL model_irq t=%0t got %b want %b", $time, timer_irq, m_flag);
            end
            if (model_rd(ALUOutM, exp_rd)) begin
                checks++;
                if (ReadDataM !== exp_rd) begin
                    errors++;
                    $display("FAIL model_rd t=%0t addr %h got %h want %h",
                             $time, ALUOutM, ReadDataM, exp_rd);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] want);
        MemWriteM = 0;
        ALUOutM   = a;
        #1;
        chk(name, ReadDataM, want);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWriteM  = 1;
        ALUOutM    = a;
        WriteDataM = d;
        step();
        MemWriteM  = 0;
    endtask

    initial begin
        reset = 1; MemWriteM = 0; ALUOutM = 0; WriteDataM = 0; sw_in = 0;
        step(); step();
        chk("rst_led", {24'd0, led_out}, 32'h0);
        chk("rst_irq", {31'd0, timer_irq}, 32'h0);
        rd("rst_cnt", 32'hFFFF_FF08, 32'h0);
        rd("rst_cmp", 32'hFFFF_FF0C, 32'hFFFF_FFFF);

        // Counter after reset release
        reset = 0;
        rd("cnt0", 32'hFFFF_FF08, 32'd0); step();
        rd("cnt1", 32'hFFFF_FF08, 32'd1); step();
        rd("cnt2", 32'hFFFF_FF08, 32'd2);
        wr(32'hFFFF_FF08, 32'hFFFF_FFFE);
        rd("cnt_ld", 32'hFFFF_FF08, 32'hFFFF_FFFE); step();
        rd("cnt_max", 32'hFFFF_FF08, 32'hFFFF_FFFF); step();
        rd("cnt_wrap", 32'hFFFF_FF08, 32'h0);
        // CNT passed through CMP reset value, so the flag is now set
        chk("irq_wrap", {31'd0, timer_irq}, 32'h1);

        // Compare / flag
        wr(32'hFFFF_FF0C, 32'd5);
        wr(32'hFFFF_FF08, 32'd0);
        wr(32'hFFFF_FF10, 32'd1);
        chk("irq_clr", {31'd0, timer_irq}, 32'h0);
        rd("stat_clr", 32'hFFFF_FF10, 32'h0);
        rd("cnt_run", 32'hFFFF_FF08, 32'd1);
        for (int i = 0; i < 4; i++) step();
        rd("cnt_at5", 32'hFFFF_FF08, 32'd5);
        chk("irq_pre", {31'd0, timer_irq}, 32'h0);
        step();
        chk("irq_set", {31'd0, timer_irq}, 32'h1);
        rd("stat_set", 32'hFFFF_FF10, 32'h1);
        wr(32'hFFFF_FF10, 32'd1);
        chk("irq_clr2", {31'd0, timer_irq}, 32'h0);
        wr(32'hFFFF_FF08, 32'd5);
        wr(32'hFFFF_FF10, 32'd1);
        chk("set_beats_clr", {31'd0, timer_irq}, 32'h1);
        wr(32'hFFFF_FF10, 32'd0);
        chk("stat_wr0", {31'd0, timer_irq}, 32'h1);

        // LED
        wr(32'hFFFF_FF00, 32'h0000_01A5);
        chk("led_out", {24'd0, led_out}, 32'hA5);
        rd("led_rd", 32'hFFFF_FF00, 32'h0000_00A5);

        // RAM
        wr(32'h10, 32'hDEAD_BEEF);
        rd("ram_10", 32'h10, 32'hDEAD_BEEF);
        rd("ram_13", 32'h13, 32'hDEAD_BEEF);
        rd("ram_oob", DEPTH*4, 32'h0);
        wr(32'h20, 32'h1234_5678);
        wr(32'h0000_0200, 32'hFFFF_FFFF);
        rd("unmap_200", 32'h0000_0200, 32'h0);
        rd("unmap_ff14", 32'hFFFF_FF14, 32'h0);
        rd("ram_20", 32'h20, 32'h1234_5678);
        wr(32'hFC, 32'hA0A0_0505);
        rd("ram_last", 32'hFC, 32'hA0A0_0505);
        rd("ram_10_kept", 32'h10, 32'hDEAD_BEEF);

        // Switches
        sw_in = 8'h3C;
        rd("sw_e0", 32'hFFFF_FF04, 32'h0); step();
        rd("sw_e1", 32'hFFFF_FF04, 32'h0); step();
        rd("sw_e2", 32'hFFFF_FF04, 32'h3C);
        wr(32'hFFFF_FF04, 32'h0000_00FF);
        rd("sw_wr_ign", 32'hFFFF_FF04, 32'h3C);

        // Reset collision: store and CNT load lost under reset
        reset = 1;
        wr(32'h20, 32'h0000_0BAD);
        wr(32'hFFFF_FF08, 32'h0000_0055);
        rd("rst_ram20", 32'h20, 32'h1234_5678);
        rd("rst_cnt2", 32'hFFFF_FF08, 32'h0);
        rd("rst_cmp2", 32'hFFFF_FF0C, 32'hFFFF_FFFF);
        rd("rst_sw", 32'hFFFF_FF04, 32'h0);
        chk("rst_led2", {24'd0, led_out}, 32'h0);
        chk("rst_irq2", {31'd0, timer_irq}, 32'h0);
        reset = 0;
        rd("post_cnt0", 32'hFFFF_FF08, 32'h0); step();
        rd("post_cnt1", 32'hFFFF_FF08, 32'h1); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
